fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/fetch_stage_pkg.sv | 36 +++
 rtl/fetch_stage_if_id_reg.sv | 49 ++++
 rtl/fetch_stage.sv | 135 +++++++++++++
 tb/tb_fetch_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_pkg
//  Purpose  : Shared definitions for the instruction-fetch stage.
//             - XLEN              : width of the IF/ID payload fields
//             - NOP_INSTR         : canonical bubble instruction (addi x0,x0,0)
//             - RESET_PC_DEFAULT  : default first fetch address after reset
//             - if_id_t           : IF/ID pipeline register payload
//             - IF_ID_BUBBLE      : IF/ID contents representing "no instruction"
//  Revision : 1.0  initial release
// ============================================================================
package fetch_stage_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } if_id_t;

    // A bubble carries a harmless NOP with zeroed PC fields so that a
    // downstream stage that ignores valid still does nothing observable.
    localparam if_id_t IF_ID_BUBBLE = '{
        instr    : NOP_INSTR,
        pc       : '0,
        pc_plus4 : '0,
        valid    : 1'b0
    };

endpackage : fetch_stage_pkg
`default_nettype wire

// File: rtl/fetch_stage_if_id_reg.sv
`default_nettype none
// ============================================================================
//  Module   : if_id_reg
//  Purpose  : IF/ID pipeline register with hold and bubble insertion.
//  Ports    : clk      - clock, rising edge
//             rst      - synchronous active-high reset (loads a bubble)
//             i_stall  - hold current contents
//             i_flush  - replace contents with a bubble (wins over i_stall)
//             i_load   - payload captured when neither stalled nor flushed
//             o_if_id  - registered payload
//  Revision : 1.0  initial release
// ============================================================================
module if_id_reg
    import fetch_stage_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   i_stall,
    input  logic   i_flush,
    input  if_id_t i_load,
    output if_id_t o_if_id
);

    if_id_t if_id_d;
    if_id_t if_id_q;

    // Flush is checked first so a squashed instruction cannot survive a
    // concurrent stall request.
    always_comb begin
        if_id_d = if_id_q;
        if (i_flush) begin
            if_id_d = IF_ID_BUBBLE;
        end else if (!i_stall) begin
            if_id_d = i_load;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            if_id_q <= IF_ID_BUBBLE;
        end else begin
            if_id_q <= if_id_d;
        end
    end

    assign o_if_id = if_id_q;

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : Instruction fetch: PC register, next-PC selection, IF/ID
//             register and accepted-instruction counter.
//  Ports    : CLK              - clock, rising edge
//             rst              - synchronous active-high reset
//             stall            - hold PC and IF/ID
//             flush            - bubble into IF/ID
//             redirect         - load PC from redirect_target (word aligned)
//             redirect_target  - new fetch address
//             imem_addr        - instruction memory address (= PC register)
//             imem_rdata       - combinational instruction memory data
//             if_id_instr      - registered instruction
//             if_id_pc         - registered PC of if_id_instr
//             if_id_pc_plus4   - registered PC + 4
//             if_id_valid      - 1 = real instruction, 0 = bubble
//             fetch_count      - instructions accepted into IF/ID (wraps)
//  Notes    : WIDTH must not exceed XLEN; IF/ID fields are XLEN wide.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT)
) (
    input  logic             CLK,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_target,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] if_id_instr,
    output logic [WIDTH-1:0] if_id_pc,
    output logic [WIDTH-1:0] if_id_pc_plus4,
    output logic             if_id_valid,
    output logic [31:0]      fetch_count
);

    localparam logic [WIDTH-1:0] c_pc_step = WIDTH'(4);

    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_q;
    logic [31:0]      fetch_count_d;
    logic [31:0]      fetch_count_q;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_redirect_pc;
    logic             w_bubble;
    logic             w_accept;
    if_id_t           w_if_id_load;
    if_id_t           w_if_id;

    // Plain modular add: the address space wraps silently.
    assign w_pc_plus4    = pc_q + c_pc_step;
    assign w_redirect_pc = {redirect_target[WIDTH-1:2], 2'b00};

    // A redirect squashes the instruction fetched down the wrong path, so it
    // bubbles IF/ID just like an explicit flush.
    assign w_bubble = flush | redirect;
    assign w_accept = ~w_bubble & ~stall;

    // ------------------------------------------------------------------
    // Next PC: redirect beats stall; flush alone does not hold the PC.
    // ------------------------------------------------------------------
    always_comb begin
        pc_d = w_pc_plus4;
        if (redirect) begin
            pc_d = w_redirect_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign imem_addr = pc_q;

    // ------------------------------------------------------------------
    // IF/ID register
    // ------------------------------------------------------------------
    always_comb begin
        w_if_id_load          = IF_ID_BUBBLE;
        w_if_id_load.instr    = XLEN'(imem_rdata);
        w_if_id_load.pc       = XLEN'(pc_q);
        w_if_id_load.pc_plus4 = XLEN'(w_pc_plus4);
        w_if_id_load.valid    = 1'b1;
    end

    if_id_reg u_if_id_reg (
        .clk     (CLK),
        .rst     (rst),
        .i_stall (stall),
        .i_flush (w_bubble),
        .i_load  (w_if_id_load),
        .o_if_id (w_if_id)
    );

    assign if_id_instr    = WIDTH'(w_if_id.instr);
    assign if_id_pc       = WIDTH'(w_if_id.pc);
    assign if_id_pc_plus4 = WIDTH'(w_if_id.pc_plus4);
    assign if_id_valid    = w_if_id.valid;

    // ------------------------------------------------------------------
    // Accepted-instruction counter: advances only when a real instruction
    // is written into IF/ID.
    // ------------------------------------------------------------------
    always_comb begin
        fetch_count_d = fetch_count_q;
        if (w_accept) begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            fetch_count_q <= 32'd0;
        end else begin
            fetch_count_q <= fetch_count_d;
        end
    end

    assign fetch_count = fetch_count_q;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed self-checking bench for fetch_stage. The instruction
//             memory model returns 32'hC000_0000 | address.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = 32'h0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic [31:0] fetch_count;

    int errors = 0;
    int checks = 0;

    always #5 CLK = ~CLK;

    assign imem_rdata = 32'hC000_0000 | imem_addr;

    fetch_stage #(
        .WIDTH    (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .CLK             (CLK),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_valid     (if_id_valid),
        .fetch_count     (fetch_count)
    );

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic [31:0] e_addr,  input logic [31:0] e_instr,
                           input logic [31:0] e_pc,    input logic [31:0] e_pc4,
                           input logic        e_valid, input logic [31:0] e_cnt);
        chk({tag, ".imem_addr"},      imem_addr,             e_addr);
        chk({tag, ".if_id_instr"},    if_id_instr,           e_instr);
        chk({tag, ".if_id_pc"},       if_id_pc,              e_pc);
        chk({tag, ".if_id_pc_plus4"}, if_id_pc_plus4,        e_pc4);
        chk({tag, ".if_id_valid"},    {31'd0, if_id_valid},  {31'd0, e_valid});
        chk({tag, ".fetch_count"},    fetch_count,           e_cnt);
    endtask

    initial begin
        // Reset, with stall/flush/redirect also active to show reset wins.
        rst = 1'b1; stall = 1'b1; flush = 1'b1; redirect = 1'b1;
        redirect_target = 32'h0000_0400;
        step();
        chk_all("rst0", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 32'd0);
        step();
        chk_all("rst1", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 32'd0);

        // Sequential fetch.
        rst = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        step();
        chk_all("seq1", 32'h4, 32'hC000_0000, 32'h0, 32'h4, 1'b1, 32'd1);
        step();
        chk_all("seq2", 32'h8, 32'hC000_0004, 32'h4, 32'h8, 1'b1, 32'd2);

        // Stall two cycles at PC=8.
        stall = 1'b1;
        step();
        chk_all("stall1", 32'h8, 32'hC000_0004, 32'h4, 32'h8, 1'b1, 32'd2);
        step();
        chk_all("stall2", 32'h8, 32'hC000_0004, 32'h4, 32'h8, 1'b1, 32'd2);
        stall = 1'b0;
        step();
        chk_all("resume", 32'hC, 32'hC000_0008, 32'h8, 32'hC, 1'b1, 32'd3);
        step();
        chk_all("seq4", 32'h10, 32'hC000_000C, 32'hC, 32'h10, 1'b1, 32'd4);

        // Redirect to an unaligned target at PC=16.
        redirect = 1'b1; redirect_target = 32'h0000_0103;
        step();
        chk_all("redir", 32'h100, 32'h13, 32'h0, 32'h0, 1'b0, 32'd4);
        redirect = 1'b0;
        step();
        chk_all("redir_next", 32'h104, 32'hC000_0100, 32'h100, 32'h104, 1'b1, 32'd5);

        // Redirect and stall together: redirect wins for the PC.
        redirect = 1'b1; stall = 1'b1; redirect_target = 32'h0000_0200;
        step();
        chk_all("redir_stall", 32'h200, 32'h13, 32'h0, 32'h0, 1'b0, 32'd5);
        redirect = 1'b0; stall = 1'b0;
        step();
        chk_all("redir_stall_next", 32'h204, 32'hC000_0200, 32'h200, 32'h204, 1'b1, 32'd6);

        // Flush and stall together: bubble, PC holds.
        flush = 1'b1; stall = 1'b1;
        step();
        chk_all("flush_stall", 32'h204, 32'h13, 32'h0, 32'h0, 1'b0, 32'd6);
        flush = 1'b0; stall = 1'b0;
        step();
        chk_all("flush_stall_next", 32'h208, 32'hC000_0204, 32'h204, 32'h208, 1'b1, 32'd7);

        // Flush alone: bubble, PC keeps advancing.
        flush = 1'b1;
        step();
        chk_all("flush", 32'h20C, 32'h13, 32'h0, 32'h0, 1'b0, 32'd7);
        flush = 1'b0;
        step();
        chk_all("flush_next", 32'h210, 32'hC000_020C, 32'h20C, 32'h210, 1'b1, 32'd8);

        // Wrap at the top of the address space.
        redirect = 1'b1; redirect_target = 32'hFFFF_FFFF;
        step();
        chk_all("wrap_redir", 32'hFFFF_FFFC, 32'h13, 32'h0, 32'h0, 1'b0, 32'd8);
        redirect = 1'b0;
        step();
        chk_all("wrap", 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd9);

        // Reset pulsed in the middle of a stall.
        stall = 1'b1;
        step();
        chk_all("pre_rst_stall", 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0, 1'b1, 32'd9);
        rst = 1'b1;
        step();
        chk_all("rst_stall", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 32'd0);
        rst = 1'b0; stall = 1'b0;
        step();
        chk_all("rst_stall_next", 32'h4, 32'hC000_0000, 32'h0, 32'h4, 1'b1, 32'd1);

        // Reset pulsed together with a redirect: pending target discarded.
        step();
        chk_all("pre_rst_redir", 32'h8, 32'hC000_0004, 32'h4, 32'h8, 1'b1, 32'd2);
        rst = 1'b1; redirect = 1'b1; redirect_target = 32'h0000_0300;
        step();
        chk_all("rst_redir", 32'h0, 32'h13, 32'h0, 32'h0, 1'b0, 32'd0);
        rst = 1'b0; redirect = 1'b0;
        step();
        chk_all("rst_redir_next", 32'h4, 32'hC000_0000, 32'h0, 32'h4, 1'b1, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fetch_stage
`default_nettype wire
